ring_phase_tracker: RTL and testbench

Downstream monitor for the N-bit one-hot ring counter. It samples the ring vector every clock and does four things: encodes the hot position into a binary phase index, emits a pulse each time the ring wraps, counts completed laps, and checks both one-hot legality and rotation order. Its outputs drive phase-indexed consumers such as digit-scan muxes and slot decoders, and they raise a fault when the ring corrupts.

---
 rtl/ring_phase_tracker.sv | 185 ++++++++++++++++++
 tb/tb_ring_phase_tracker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker: monitors a one-hot ring counter. It encodes the hot position
// into a binary phase index, pulses wrap on every N-1 -> 0 step, counts laps,
// and flags illegal (not one-hot) or out-of-order ring values.
// Optional feature macro: RING_PHASE_TRACKER_LAP_EN builds the lap counter.
// When the macro is undefined, laps_o is tied to zero.
module ring_phase_tracker #(
   parameter int N    = 10,
   parameter int IDXW = $clog2(N),
   parameter int LAPW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [N-1:0]    ring_i,
   output logic            valid_o,
   output logic [IDXW-1:0] idx_o,
   output logic            wrap_o,
   output logic            err_onehot_o,
   output logic            err_seq_o,
   output logic            err_sticky_o,
   output logic [LAPW-1:0] laps_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    prev_q, prev_d;
   logic            valid_q, valid_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            wrap_q, wrap_d;
   logic            err_onehot_q, err_onehot_d;
   logic            err_seq_q, err_seq_d;
   logic            err_sticky_q, err_sticky_d;
   logic            legal_s;
   logic [N-1:0]    expected_s;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [N-1:0] v);
      logic [N-1:0] low_cleared;
      low_cleared = v & (v - {{(N-1){1'b0}}, 1'b1});
      return (v != {N{1'b0}}) && (low_cleared == {N{1'b0}});
   endfunction

   // Binary index of the set bit (meaningful only for one-hot input).
   function automatic logic [IDXW-1:0] encode(input logic [N-1:0] v);
      logic [IDXW-1:0] e;
      e = {IDXW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            e = e | IDXW'(i);
         end else begin
            e = e;
         end
      end
      return e;
   endfunction

   assign legal_s    = is_onehot(ring_i);
   assign expected_s = {prev_q[N-2:0], prev_q[N-1]};

   // Next-state and next-output logic for the tracker FSM.
   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      valid_d      = valid_q;
      idx_d        = idx_q;
      wrap_d       = 1'b0;
      err_onehot_d = 1'b0;
      err_seq_d    = 1'b0;
      err_sticky_d = err_sticky_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start_i) begin
               state_d = IDLE;
            end else if (legal_s) begin
               state_d = TRACK;
               prev_d  = ring_i;
               idx_d   = encode(ring_i);
               valid_d = 1'b1;
            end else begin
               state_d      = FAULT;
               err_onehot_d = 1'b1;
               err_sticky_d = 1'b1;
            end
         end
         TRACK: begin
            if (start_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else if (!legal_s) begin
               state_d      = FAULT;
               valid_d      = 1'b0;
               err_onehot_d = 1'b1;
               err_sticky_d = 1'b1;
            end else if (ring_i != expected_s) begin
               state_d      = FAULT;
               valid_d      = 1'b0;
               err_seq_d    = 1'b1;
               err_sticky_d = 1'b1;
            end else begin
               prev_d = ring_i;
               idx_d  = encode(ring_i);
               wrap_d = prev_q[N-1] & ring_i[0];
            end
         end
         FAULT: begin
            valid_d = 1'b0;
            if (start_i) begin
               state_d      = IDLE;
               err_sticky_d = 1'b0;
            end else begin
               state_d      = FAULT;
               err_sticky_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Tracker state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_q       <= {N{1'b0}};
         valid_q      <= 1'b0;
         idx_q        <= {IDXW{1'b0}};
         wrap_q       <= 1'b0;
         err_onehot_q <= 1'b0;
         err_seq_q    <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         valid_q      <= valid_d;
         idx_q        <= idx_d;
         wrap_q       <= wrap_d;
         err_onehot_q <= err_onehot_d;
         err_seq_q    <= err_seq_d;
         err_sticky_q <= err_sticky_d;
      end
   end

`ifdef RING_PHASE_TRACKER_LAP_EN
   logic [LAPW-1:0] laps_q, laps_d;

   // Lap count advances with each wrap; wraps modulo 2^LAPW silently.
   always_comb begin
      laps_d = laps_q;
      if (wrap_d) begin
         laps_d = laps_q + {{(LAPW-1){1'b0}}, 1'b1};
      end else begin
         laps_d = laps_q;
      end
   end

   // Lap counter register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         laps_q <= {LAPW{1'b0}};
      end else begin
         laps_q <= laps_d;
      end
   end

   assign laps_o = laps_q;
`else
   assign laps_o = {LAPW{1'b0}};
`endif

   assign valid_o      = valid_q;
   assign idx_o        = idx_q;
   assign wrap_o       = wrap_q;
   assign err_onehot_o = err_onehot_q;
   assign err_seq_o    = err_seq_q;
   assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_ring_phase_tracker.sv
// Scoreboard bench for ring_phase_tracker (N = 10). A behavioural model predicts
// each cycle's outputs when the stimulus is driven. The prediction is queued and
// then compared against the DUT one clock later. A second instance with LAPW = 2
// covers lap-counter modulo wrap.
module tb_ring_phase_tracker;

   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
      logic       wrap;
      logic       eoh;
      logic       eseq;
      logic       sticky;
      logic [7:0] laps;
      logic [1:0] laps2;
   } obs_t;

`ifdef RING_PHASE_TRACKER_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] ring;
   logic       valid, wrap, eoh, eseq, sticky;
   logic [3:0] idx;
   logic [7:0] laps;
   logic       valid2, wrap2, eoh2, eseq2, sticky2;
   logic [3:0] idx2;
   logic [1:0] laps2;

   int passed = 0;
   int total  = 0;

   obs_t sb[$];
   int         m_st;
   logic [9:0] m_prev;
   logic [3:0] m_idx;
   logic       m_valid, m_sticky;
   logic [7:0] m_laps;
   logic [1:0] m_laps2;
   logic [9:0] rc;

   ring_phase_tracker #(.N(10), .LAPW(8)) dut (
      .clk(clk), .rst(rst), .start_i(start), .ring_i(ring),
      .valid_o(valid), .idx_o(idx), .wrap_o(wrap), .err_onehot_o(eoh),
      .err_seq_o(eseq), .err_sticky_o(sticky), .laps_o(laps));

   ring_phase_tracker #(.N(10), .LAPW(2)) dut2 (
      .clk(clk), .rst(rst), .start_i(start), .ring_i(ring),
      .valid_o(valid2), .idx_o(idx2), .wrap_o(wrap2), .err_onehot_o(eoh2),
      .err_seq_o(eseq2), .err_sticky_o(sticky2), .laps_o(laps2));

   always #5 clk = ~clk;

   function automatic obs_t pack_obs();
      obs_t o;
      o = {valid, idx, wrap, eoh, eseq, sticky, laps, laps2};
      return o;
   endfunction

   task automatic model_clear();
      m_st = 0; m_prev = 10'd0; m_idx = 4'd0; m_valid = 1'b0; m_sticky = 1'b0;
      m_laps = 8'd0; m_laps2 = 2'd0;
      sb.delete();
   endtask

   // Drive one cycle of stimulus, queue the predicted outputs, advance one clock.
   task automatic step(input logic st, input logic [9:0] r);
      obs_t e;
      logic legal;
      logic [9:0] expd;
      logic [3:0] enc;
      start = st;
      ring  = r;
      legal = ($countones(r) == 1);
      expd  = {m_prev[8:0], m_prev[9]};
      enc   = 4'd0;
      for (int i = 0; i < 10; i++) if (r[i]) enc = 4'(i);
      e = '0;
      if (st) m_sticky = 1'b0;
      case (m_st)
         0: begin
            m_valid = 1'b0;
            if (!st) begin
               if (legal) begin
                  m_st = 1; m_prev = r; m_idx = enc; m_valid = 1'b1;
               end else begin
                  m_st = 2; e.eoh = 1'b1; m_sticky = 1'b1;
               end
            end
         end
         1: begin
            if (st) begin
               m_st = 0; m_valid = 1'b0;
            end else if (!legal) begin
               m_st = 2; m_valid = 1'b0; e.eoh = 1'b1; m_sticky = 1'b1;
            end else if (r != expd) begin
               m_st = 2; m_valid = 1'b0; e.eseq = 1'b1; m_sticky = 1'b1;
            end else begin
               e.wrap = m_prev[9] & r[0];
               if (e.wrap) begin
                  m_laps  = m_laps + 8'd1;
                  m_laps2 = m_laps2 + 2'd1;
               end
               m_prev = r; m_idx = enc;
            end
         end
         default: begin
            m_valid = 1'b0;
            if (st) m_st = 0;
         end
      endcase
      e.valid = m_valid; e.idx = m_idx; e.sticky = m_sticky;
      e.laps  = LAP_ON ? m_laps : 8'd0;
      e.laps2 = LAP_ON ? m_laps2 : 2'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Ring counter stand-in: loads 0..01 on start, otherwise rotates left.
   task automatic ring_step(input logic st);
      step(st, rc);
      rc = st ? 10'd1 : {rc[8:0], rc[9]};
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b1; ring = 10'd1; rc = 10'd1;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e;
      do_reset();
      total++;
      if (pack_obs() !== obs_t'(0)) $display("FAIL reset_values got %h want 0", pack_obs());
      else passed++;
      ring_step(1'b1);
      e = sb.pop_front();
      total++;
      if (pack_obs() !== e) $display("FAIL reset_idle got %h want %h", pack_obs(), e);
      else passed++;
   endtask

   task automatic test_tracking();
      obs_t e;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         ring_step(1'b1);
         e = sb.pop_front();
         total++;
         if (pack_obs() !== e) $display("FAIL track_start got %h want %h", pack_obs(), e);
         else passed++;
      end
      for (int k = 0; k <= 10; k++) begin
         ring_step(1'b0);
         e = sb.pop_front();
         total++;
         if (pack_obs() !== e) $display("FAIL track_sb k=%0d got %h want %h", k, pack_obs(), e);
         else passed++;
         total++;
         if ({valid, idx, wrap} !== {1'b1, 4'(k % 10), (k == 10)})
            $display("FAIL track_idx k=%0d got %b/%0d/%b want 1/%0d/%b", k, valid, idx, wrap, k % 10, k == 10);
         else passed++;
      end
   endtask

   task automatic test_laps();
      obs_t e;
      int nwrap;
      nwrap = 0;
      do_reset();
      ring_step(1'b1);
      e = sb.pop_front();
      for (int k = 0; k <= 250; k++) begin
         ring_step(1'b0);
         e = sb.pop_front();
         if (wrap) nwrap++;
         total++;
         if (pack_obs() !== e) $display("FAIL laps_sb k=%0d got %h want %h", k, pack_obs(), e);
         else passed++;
         total++;
         if ({valid2, idx2, wrap2, eoh2, eseq2, sticky2} !== {e.valid, e.idx, e.wrap, e.eoh, e.eseq, e.sticky})
            $display("FAIL laps_dut2 k=%0d got %b/%0d/%b want %b/%0d/%b", k, valid2, idx2, wrap2, e.valid, e.idx, e.wrap);
         else passed++;
         if (k == 50) begin
            total++;
            if (laps2 !== (LAP_ON ? 2'd1 : 2'd0)) $display("FAIL laps_mod4 got %0d want %0d", laps2, LAP_ON ? 1 : 0);
            else passed++;
         end
      end
      total++;
      if (nwrap != 25) $display("FAIL wrap_count got %0d want 25", nwrap);
      else passed++;
      total++;
      if (laps !== (LAP_ON ? 8'd25 : 8'd0)) $display("FAIL laps_25 got %0d want %0d", laps, LAP_ON ? 25 : 0);
      else passed++;
   endtask

   // Runs to idx 2 then injects bad, and holds FAULT until start.
   task automatic test_fault(input logic [9:0] bad, input logic want_oh);
      obs_t e;
      do_reset();
      ring_step(1'b1);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         ring_step(1'b0);
         e = sb.pop_front();
      end
      step(1'b0, bad);
      e = sb.pop_front();
      total++;
      if (pack_obs() !== e) $display("FAIL fault_sb got %h want %h", pack_obs(), e);
      else passed++;
      total++;
      if ({eoh, eseq, valid, sticky, idx} !== {want_oh, ~want_oh, 1'b0, 1'b1, 4'd2})
         $display("FAIL fault_entry got %b%b%b%b/%0d want %b%b01/2", eoh, eseq, valid, sticky, idx, want_oh, ~want_oh);
      else passed++;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 10'($urandom));
         e = sb.pop_front();
         total++;
         if ({eoh, eseq, valid, sticky, idx} !== {4'b0001, 4'd2})
            $display("FAIL fault_hold got %b%b%b%b/%0d want 0001/2", eoh, eseq, valid, sticky, idx);
         else passed++;
      end
      step(1'b1, 10'd1);
      e = sb.pop_front();
      total++;
      if (pack_obs() !== e || sticky !== 1'b0) $display("FAIL fault_clear got %h want %h", pack_obs(), e);
      else passed++;
   endtask

   task automatic test_start_priority();
      obs_t e;
      do_reset();
      ring_step(1'b1);
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
         ring_step(1'b0);
         e = sb.pop_front();
      end
      step(1'b1, 10'b0000000000);
      e = sb.pop_front();
      total++;
      if (pack_obs() !== e || {eoh, eseq, valid} !== 3'b000)
         $display("FAIL start_priority got %h want %h", pack_obs(), e);
      else passed++;
   endtask

   task automatic test_async_reset();
      obs_t e;
      do_reset();
      ring_step(1'b1);
      e = sb.pop_front();
      for (int k = 0; k <= 16; k++) begin
         ring_step(1'b0);
         e = sb.pop_front();
         total++;
         if (pack_obs() !== e) $display("FAIL arst_run k=%0d got %h want %h", k, pack_obs(), e);
         else passed++;
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (pack_obs() !== obs_t'(0)) $display("FAIL async_reset got %h want 0", pack_obs());
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; ring = 10'd1; rc = 10'd1;
      model_clear();
      test_reset();
      test_tracking();
      test_laps();
      test_fault(10'b0000001100, 1'b1);
      test_fault(10'b0000100000, 1'b0);
      test_start_priority();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
